// File: rtl/pstore_sequencer_if.sv
// Control bundle between the pStore sequencer and its datapath/host; sequencer uses the slave view.
interface pstore_sequencer_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic             acc_en;
    logic             acc_clr;
    logic [CNT_W-1:0] weight_addr;
    logic             sum_valid;
    logic             sum_ready;
    logic             busy;
    logic             done;
    logic             start_err;

    modport master (
        output start, abort, in_valid, sum_ready,
        input  in_ready, acc_en, acc_clr, weight_addr, sum_valid, busy, done, start_err
    );

    modport slave (
        input  start, abort, in_valid, sum_ready,
        output in_ready, acc_en, acc_clr, weight_addr, sum_valid, busy, done, start_err
    );
endinterface

// File: rtl/pstore_sequencer.sv
// Sequences one pStore pass: clear, accumulate N_INPUTS inputs, settle, present; N_INPUTS+3 cycles minimum.
// Inputs stall on in_valid=0; sum_valid holds until sum_ready; abort wins over every other request.
module pstore_sequencer #(
    parameter int N_INPUTS = 784,
    parameter int CNT_W    = 10
) (
    input logic               clk,
    input logic               clr,
    pstore_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCUM   = 3'd2,
        S_SETTLE  = 3'd3,
        S_PRESENT = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             start_err_q, start_err_d;
    logic             accept;
    logic             release_ok;

    assign accept     = (state_q == S_ACCUM) && bus.in_valid && !bus.abort;
    assign release_ok = (state_q == S_PRESENT) && bus.sum_ready && !bus.abort;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = release_ok;
        start_err_d = bus.start && (state_q != S_IDLE) && !release_ok;

        case (state_q)
            S_IDLE:    if (bus.start) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_ACCUM;
            S_ACCUM:   if (accept && cnt_q == LAST) state_d = S_SETTLE;
            S_SETTLE:  state_d = S_PRESENT;
            S_PRESENT: if (bus.sum_ready) state_d = bus.start ? S_CLEAR : S_IDLE;
            S_ABORT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Abort reuses a clear cycle but returns to IDLE instead of ACCUM.
        if (bus.abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d = S_ABORT;
        end

        if (state_q == S_CLEAR || state_q == S_ABORT) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.in_ready    = 1'b0;
        bus.acc_en      = 1'b0;
        bus.acc_clr     = 1'b0;
        bus.weight_addr = '0;
        bus.sum_valid   = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.start_err   = 1'b0;

        // Outputs are forced quiet while clr is low, even before the first edge.
        if (clr) begin
            case (state_q)
                S_CLEAR, S_ABORT: bus.acc_clr = 1'b1;
                S_ACCUM: begin
                    bus.in_ready    = !bus.abort;
                    bus.acc_en      = accept;
                    bus.weight_addr = cnt_q;
                end
                S_PRESENT: bus.sum_valid = 1'b1;
                default: ;
            endcase
            bus.busy      = (state_q != S_IDLE);
            bus.done      = done_q;
            bus.start_err = start_err_q;
        end else begin
            bus.acc_clr = 1'b1;
        end
    end
endmodule

// File: tb/tb_pstore_sequencer.sv
// Scoreboard bench for pstore_sequencer with a 4-input pass and a behavioural pStore accumulator.
module tb_pstore_sequencer;
    localparam int N  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    pstore_sequencer_if #(.CNT_W(CW)) bus ();

    pstore_sequencer #(.N_INPUTS(N), .CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_en_cnt = 0, acc_clr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int   cyc_cnt = 0, t_start = 0, t_sv = 0;
    int   pass_id = 0;
    int   acc_sum = 0;
    int   act_cur = 0;
    int   weights [N] = '{3, 5, 7, 11};
    int   exp_addr [$];
    int   exp_sum [$];
    logic sv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int act_of(input int p, input int i);
        return p * 3 + i + 1;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural pStore accumulator driven by the sequencer's controls.
    always @(posedge clk) begin
        if (bus.acc_clr) acc_sum <= 0;
        else if (bus.acc_en) acc_sum <= acc_sum + weights[bus.weight_addr % N] * act_cur;
    end

    always @(negedge clk) begin
        if (clr) begin
            if (bus.acc_clr)   acc_clr_cnt++;
            if (bus.done)      done_cnt++;
            if (bus.start_err) err_cnt++;
            if (bus.acc_en) begin
                acc_en_cnt++;
                if (exp_addr.size() == 0) check("acc_en_unexpected", bus.acc_en, 0);
                else check("weight_addr", bus.weight_addr, exp_addr.pop_front());
            end
            if (bus.sum_valid && !sv_prev) begin
                t_sv = cyc_cnt;
                if (exp_sum.size() == 0) check("sum_unexpected", bus.sum_valid, 0);
                else check("sum", acc_sum, exp_sum.pop_front());
            end
        end
        sv_prev = bus.sum_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        acc_en_cnt = 0; acc_clr_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic push_pass();
        int s = 0;
        pass_id++;
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(i);
            s += weights[i] * act_of(pass_id, i);
        end
        exp_sum.push_back(s);
    endtask

    task automatic do_start();
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        t_start      = cyc_cnt;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic accum(input logic [31:0] pat, input int plen);
        int k = 0;
        for (int i = 0; i < plen; i++) begin
            bus.in_valid = pat[i];
            act_cur      = act_of(pass_id, k);
            @(negedge clk);
            check("addr_hold", bus.weight_addr, k);
            check("in_ready_accum", bus.in_ready, 1);
            if (bus.in_valid && bus.in_ready) k++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sv();
        int n = 0;
        @(negedge clk);
        while (!bus.sum_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sum_valid_reached", bus.sum_valid, 1);
        tick();
    endtask

    task automatic ack();
        bus.sum_ready = 1'b1;
        @(negedge clk);
        check("sum_valid_at_ack", bus.sum_valid, 1);
        tick();
        bus.sum_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", bus.done, 1);
        check("idle_after_done", bus.busy, 0);
        tick();
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_in_ready"},    bus.in_ready, 0);
        check({pfx, "_acc_en"},      bus.acc_en, 0);
        check({pfx, "_sum_valid"},   bus.sum_valid, 0);
        check({pfx, "_busy"},        bus.busy, 0);
        check({pfx, "_done"},        bus.done, 0);
        check({pfx, "_start_err"},   bus.start_err, 0);
        check({pfx, "_weight_addr"}, bus.weight_addr, 0);
        check({pfx, "_acc_clr"},     bus.acc_clr, 1);
    endtask

    task automatic run_full(input string pfx);
        clear_counts();
        push_pass();
        do_start();
        tick();
        accum('1, N);
        wait_sv();
        check({pfx, "_latency"}, t_sv - t_start, N + 3);
        ack();
        check({pfx, "_acc_en_cnt"}, acc_en_cnt, N);
        check({pfx, "_acc_clr_cnt"}, acc_clr_cnt, 1);
        check({pfx, "_done_cnt"}, done_cnt, 1);
        check({pfx, "_err_cnt"}, err_cnt, 0);
        check({pfx, "_addr_left"}, exp_addr.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.sum_ready = 1'b0;

        // Reset, with in_valid asserted to show it has no effect.
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_quiet("rst");
        bus.in_valid = 1'b0;
        tick();
        clr = 1'b1;
        @(negedge clk);
        check("rst_release_acc_clr", bus.acc_clr, 0);
        check("rst_release_busy", bus.busy, 0);
        tick();

        // Back-to-back valid inputs, minimum latency.
        run_full("basic");

        // Stalls in the input stream.
        clear_counts();
        push_pass();
        do_start();
        bus.in_valid = 1'b0;
        tick();
        accum(32'b1011001, 7);
        wait_sv();
        ack();
        check("stall_acc_en_cnt", acc_en_cnt, N);
        check("stall_done_cnt", done_cnt, 1);

        // Downstream backpressure with an illegal start.
        clear_counts();
        push_pass();
        do_start();
        tick();
        accum('1, N);
        wait_sv();
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 4);
            @(negedge clk);
            check("hold_sum_valid", bus.sum_valid, 1);
            check("hold_acc_en", bus.acc_en, 0);
            tick();
        end
        bus.start = 1'b0;
        check("bp_start_err_cnt", err_cnt, 1);
        ack();
        check("bp_done_cnt", done_cnt, 1);
        check("bp_acc_clr_cnt", acc_clr_cnt, 1);

        // Abort at weight_addr 2.
        clear_counts();
        push_pass();
        do_start();
        tick();
        accum('1, 2);
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("abort_addr", bus.weight_addr, 2);
        check("abort_no_acc", bus.acc_en, 0);
        tick();
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_acc_clr", bus.acc_clr, 1);
        tick();
        @(negedge clk);
        check("abort_idle", bus.busy, 0);
        repeat (3) tick();
        exp_addr.delete();
        void'(exp_sum.pop_back());
        check("abort_acc_en_cnt", acc_en_cnt, 2);
        check("abort_acc_clr_cnt", acc_clr_cnt, 2);
        check("abort_done_cnt", done_cnt, 0);
        run_full("post_abort");

        // Start together with sum_ready.
        clear_counts();
        push_pass();
        do_start();
        tick();
        accum('1, N);
        wait_sv();
        push_pass();
        bus.sum_ready = 1'b1;
        bus.start     = 1'b1;
        t_start       = cyc_cnt;
        tick();
        bus.sum_ready = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("b2b_done", bus.done, 1);
        check("b2b_acc_clr", bus.acc_clr, 1);
        check("b2b_start_err", bus.start_err, 0);
        check("b2b_busy", bus.busy, 1);
        tick();
        accum('1, N);
        wait_sv();
        check("b2b_latency", t_sv - t_start, N + 3);
        ack();
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_err_cnt", err_cnt, 0);
        check("b2b_acc_clr_cnt", acc_clr_cnt, 2);

        // Reset in the middle of accumulation.
        clear_counts();
        push_pass();
        do_start();
        tick();
        accum('1, 2);
        clr = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        tick();
        @(negedge clk);
        check_quiet("midrst_held");
        tick();
        clr = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_release_acc_clr", bus.acc_clr, 0);
        check("midrst_release_busy", bus.busy, 0);
        tick();
        exp_addr.delete();
        void'(exp_sum.pop_back());
        check("midrst_done_cnt", done_cnt, 0);
        run_full("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pstore_sequencer.md
PSTORE_SEQUENCER -- requirements
Module: pstore_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 784: number of weighted inputs accumulated per pass.
REQ-002 SHALL have parameter CNT_W, default 10: width of the input counter and address, with 2^CNT_W >= N_INPUTS.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge clk.
REQ-004 SHALL have port clr, input, 1 bit: synchronous, active-low reset; clr=0 at a posedge resets the block.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin one accumulation pass.
REQ-006 SHALL have port abort, input, 1 bit: cancels the pass in progress.
REQ-007 SHALL have port in_valid, input, 1 bit: an input activation is available.
REQ-008 SHALL have port in_ready, output, 1 bit: the sequencer accepts an input this cycle.
REQ-009 SHALL have port acc_en, output, 1 bit: the datapath presents the addressed weights to the pStore adders (0 = present zero weights).
REQ-010 SHALL have port acc_clr, output, 1 bit: active-high clear to the pStore accumulators.
REQ-011 SHALL have port weight_addr, output, CNT_W bits: index of the input being accumulated.
REQ-012 SHALL have port sum_valid, output, 1 bit: pStore sumOut is final and stable.
REQ-013 SHALL have port sum_ready, input, 1 bit: the downstream ReLU stage has taken sumOut.
REQ-014 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-016 SHALL have port start_err, output, 1 bit: one-cycle pulse when start is seen while busy.

Function
REQ-017 SHALL implement states IDLE, CLEAR, ACCUM, SETTLE, PRESENT, plus a counter cnt[CNT_W-1:0].
REQ-018 In IDLE, start=1 SHALL move the state to CLEAR; otherwise the state SHALL stay in IDLE.
REQ-019 In CLEAR, the block SHALL drive acc_clr=1 for exactly one cycle, set cnt=0 and move to ACCUM.
REQ-020 In ACCUM, in_ready SHALL be 1 and weight_addr SHALL equal cnt.
REQ-021 In ACCUM, acc_en SHALL equal in_valid (combinational, same cycle) and SHALL be 0 in every other state.
REQ-022 In ACCUM, each in_valid&in_ready cycle SHALL increment cnt by 1; cycles with in_valid=0 SHALL hold cnt (stall, no accumulation).
REQ-023 When the accepted input has cnt==N_INPUTS-1, the next state SHALL be SETTLE, cnt SHALL wrap to 0, and no further inputs SHALL be accepted.
REQ-024 SETTLE SHALL last exactly one cycle, covering the pStore register latency, then move to PRESENT.
REQ-025 In PRESENT, sum_valid SHALL be 1 and SHALL hold until sum_ready=1.
REQ-026 On sum_ready=1 in PRESENT, done SHALL pulse for one cycle and the state SHALL move to IDLE, or to CLEAR if start=1 in that same cycle (back-to-back pass, no start_err).
REQ-027 Minimum pass latency from start to sum_valid SHALL be N_INPUTS+3 cycles.
REQ-028 abort=1 in any non-IDLE state SHALL move the state to CLEAR-then-IDLE: acc_clr pulses one cycle, then IDLE, with no done pulse.
REQ-029 abort SHALL take priority over in_valid, sum_ready and start in the same cycle; abort in IDLE SHALL be ignored.
REQ-030 start=1 while busy=1 (except the REQ-026 case) SHALL be ignored and SHALL pulse start_err.
REQ-031 in_ready SHALL be 0 outside ACCUM; in_valid outside ACCUM SHALL have no effect.

Reset
REQ-032 clr=0 SHALL, at the next posedge, force state to IDLE and cnt to 0.
REQ-033 During and after reset, in_ready, acc_en, sum_valid, busy, done, start_err and weight_addr SHALL be 0.
REQ-034 During reset, acc_clr SHALL be 1; it SHALL be 0 from the first cycle after clr returns to 1.
REQ-035 Reset asserted mid-pass SHALL discard the pass with no done pulse.

Verification
REQ-036 N_INPUTS=4, start, in_valid held 1 -> acc_clr one cycle; acc_en for 4 cycles with weight_addr 0,1,2,3; sum_valid 7 cycles after start; sum_ready -> done one cycle; busy=0.
REQ-037 N_INPUTS=4, in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 acc_en cycles, weight_addr 0..3 in order, cnt held across the gaps.
REQ-038 sum_ready held 0 for 10 cycles in PRESENT -> sum_valid stays 1 and acc_en stays 0; start during this time -> start_err pulses and the state is unchanged.
REQ-039 abort at weight_addr=2 -> acc_clr pulses, IDLE follows, no done; a new start then reaches sum_valid with correct sums.
REQ-040 start together with sum_ready in PRESENT -> done pulses and CLEAR follows immediately, with no start_err.
REQ-041 clr=0 mid-ACCUM -> all REQ-033 outputs 0; after release, the next start runs a full correct pass.
